// File: rtl/mux_pipe_stage.sv
// Registered N-way selector with valid/ready on both sides and a 2-entry skid buffer.
// The select is evaluated when a beat is captured and travels with it as out_sel/out_err.
module mux_pipe_stage #(
    parameter int WIDTH  = 32,
    parameter int INPUTS = 4,
    localparam int SEL_W = $clog2(INPUTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [INPUTS*WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_err
);

    logic             mValid;
    logic [WIDTH-1:0] mData;
    logic [SEL_W-1:0] mSel;
    logic             mErr;

    logic             sValid;
    logic [WIDTH-1:0] sData;
    logic [SEL_W-1:0] sSel;
    logic             sErr;

    logic             inXfer;
    logic             outXfer;
    logic             mFree;
    logic [WIDTH-1:0] capData;
    logic             capErr;

    // An out-of-range select can only occur when INPUTS leaves unused codes.
    generate
        if ((1 << SEL_W) == INPUTS) begin : g_pow2
            assign capErr = 1'b0;
        end else begin : g_npow2
            assign capErr = ({1'b0, in_sel} >= (SEL_W + 1)'(INPUTS));
        end
    endgenerate

    always_comb begin
        capData = '0;
        for (int k = 0; k < INPUTS; k++) begin
            if (in_sel == SEL_W'(k)) begin
                capData = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready  = ~sValid & ~flush;
    assign inXfer    = in_valid & in_ready;
    assign outXfer   = mValid & out_ready;
    assign mFree     = ~mValid | outXfer;

    assign out_valid = mValid;
    assign out_data  = mData;
    assign out_sel   = mSel;
    assign out_err   = mErr;

    always_ff @(posedge clk) begin
        if (reset) begin
            mValid <= 1'b0;
            mData  <= '0;
            mSel   <= '0;
            mErr   <= 1'b0;
            sValid <= 1'b0;
            sData  <= '0;
            sSel   <= '0;
            sErr   <= 1'b0;
        end else if (flush) begin
            mValid <= 1'b0;
            sValid <= 1'b0;
        end else if (mFree) begin
            if (sValid) begin
                // in_ready is low while S is occupied, so no new beat competes here.
                mValid <= 1'b1;
                mData  <= sData;
                mSel   <= sSel;
                mErr   <= sErr;
                sValid <= 1'b0;
            end else if (inXfer) begin
                mValid <= 1'b1;
                mData  <= capData;
                mSel   <= in_sel;
                mErr   <= capErr;
            end else begin
                mValid <= 1'b0;
            end
        end else if (inXfer) begin
            sValid <= 1'b1;
            sData  <= capData;
            sSel   <= in_sel;
            sErr   <= capErr;
        end
    end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Drives a 4-input and a 3-input instance with identical handshakes and checks both
// against a queue-based model of the buffered beats.
module tb_mux_pipe_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  in_sel;
    logic [127:0] dIn4;
    logic [95:0]  dIn3;

    logic        rdy4, rdy3;
    logic        ov4, ov3;
    logic [31:0] od4, od3;
    logic [1:0]  os4, os3;
    logic        oe4, oe3;

    mux_pipe_stage #(.WIDTH(32), .INPUTS(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy4), .in_sel(in_sel), .in_data(dIn4),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_sel(os4), .out_err(oe4)
    );

    mux_pipe_stage #(.WIDTH(32), .INPUTS(3)) dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy3), .in_sel(in_sel), .in_data(dIn3),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .out_sel(os3), .out_err(oe3)
    );

    typedef struct {
        logic [31:0] d4;
        logic        e4;
        logic [31:0] d3;
        logic        e3;
        logic [1:0]  sel;
    } beat_t;

    beat_t       q[$];
    logic [31:0] w [4];
    int          nTests = 0;
    int          nFail  = 0;
    bit          checking = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randWords();
        for (int i = 0; i < 4; i++) w[i] = $urandom;
    endtask

    // Called at a falling edge; applies inputs for the next rising edge and checks both sides.
    task automatic stepCycle(input bit rst, input bit fl, input bit iv, input bit ordy,
                             input logic [1:0] sel);
        beat_t b;
        bit    expRdy;
        bit    outX;
        bit    inX;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_sel    = sel;
        dIn4      = {w[3], w[2], w[1], w[0]};
        dIn3      = {w[2], w[1], w[0]};
        #1;
        expRdy = (q.size() < 2) && !fl;
        if (checking) begin
            checkVal("in_ready4", 32'(rdy4), 32'(expRdy));
            checkVal("in_ready3", 32'(rdy3), 32'(expRdy));
        end
        if (rst || fl) begin
            q.delete();
        end else begin
            outX = (q.size() > 0) && ordy;
            inX  = iv && expRdy;
            if (outX) void'(q.pop_front());
            if (inX) begin
                b.sel = sel;
                b.d4  = w[sel];
                b.e4  = 1'b0;
                b.e3  = (sel == 2'd3);
                b.d3  = (sel == 2'd3) ? 32'd0 : w[sel];
                q.push_back(b);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (checking) begin
            checkVal("out_valid4", 32'(ov4), 32'(q.size() > 0));
            checkVal("out_valid3", 32'(ov3), 32'(q.size() > 0));
            if (q.size() > 0) begin
                checkVal("out_data4", od4, q[0].d4);
                checkVal("out_sel4", 32'(os4), 32'(q[0].sel));
                checkVal("out_err4", 32'(oe4), 32'(q[0].e4));
                checkVal("out_data3", od3, q[0].d3);
                checkVal("out_sel3", 32'(os3), 32'(q[0].sel));
                checkVal("out_err3", 32'(oe3), 32'(q[0].e3));
            end
        end
    endtask

    initial begin
        logic [31:0] held;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sel = 2'd0;
        dIn4 = '0; dIn3 = '0;
        for (int i = 0; i < 4; i++) w[i] = '0;
        @(negedge clk);

        stepCycle(1, 0, 0, 0, 2'd0);
        checking = 1;
        stepCycle(1, 0, 0, 0, 2'd0);
        checkVal("rst_data", od4, 32'd0);
        checkVal("rst_sel", 32'(os4), 32'd0);

        // Single beat, sel=2 selects the third word.
        w[0] = 32'hAAAA_0000; w[1] = 32'hBBBB_1111; w[2] = 32'hCCCC_2222; w[3] = 32'hDDDD_3333;
        stepCycle(0, 0, 1, 1, 2'd2);
        checkVal("t1_data", od4, 32'hCCCC_2222);
        checkVal("t1_sel", 32'(os4), 32'd2);
        checkVal("t1_err", 32'(oe4), 32'd0);
        stepCycle(0, 0, 0, 1, 2'd0);

        // Full-rate stream.
        for (int i = 0; i < 8; i++) begin
            randWords();
            stepCycle(0, 0, 1, 1, 2'($urandom_range(0, 3)));
            checkVal("t2_ready", 32'(rdy4), 32'd1);
        end
        stepCycle(0, 0, 0, 1, 2'd0);

        // Back-pressure: third beat refused, head held stable.
        for (int i = 0; i < 3; i++) begin
            randWords();
            stepCycle(0, 0, 1, 0, 2'($urandom_range(0, 3)));
            if (i == 0) held = od4;
        end
        checkVal("t3_ready", 32'(rdy4), 32'd0);
        checkVal("t3_stable", od4, held);
        for (int i = 0; i < 3; i++) stepCycle(0, 0, 0, 1, 2'd0);
        checkVal("t3_ready_back", 32'(rdy4), 32'd1);

        // Out-of-range select on the 3-input instance.
        randWords();
        stepCycle(0, 0, 1, 1, 2'd3);
        checkVal("t4_err", 32'(oe3), 32'd1);
        checkVal("t4_data", od3, 32'd0);
        stepCycle(0, 0, 1, 1, 2'd1);
        checkVal("t4_err_clr", 32'(oe3), 32'd0);
        stepCycle(0, 0, 0, 1, 2'd0);

        // Flush with both entries full.
        for (int i = 0; i < 2; i++) begin
            randWords();
            stepCycle(0, 0, 1, 0, 2'($urandom_range(0, 3)));
        end
        randWords();
        stepCycle(0, 1, 1, 0, 2'd1);
        checkVal("t5_valid", 32'(ov4), 32'd0);
        stepCycle(0, 0, 0, 1, 2'd0);
        stepCycle(0, 0, 0, 1, 2'd0);

        // Reset mid-stream.
        for (int i = 0; i < 2; i++) begin
            randWords();
            stepCycle(0, 0, 1, 0, 2'($urandom_range(0, 3)));
        end
        stepCycle(1, 0, 0, 0, 2'd0);
        checkVal("t6_data4", od4, 32'd0);
        checkVal("t6_data3", od3, 32'd0);
        checkVal("t6_err3", 32'(oe3), 32'd0);
        stepCycle(0, 0, 0, 0, 2'd0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            randWords();
            stepCycle(($urandom_range(0, 99) == 0),
                      ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 2) != 0),
                      2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
